// File: rtl/count_ctrl_pkg.sv
// Shared types and default parameters for the counter command stage.
package count_ctrl_pkg;

    typedef enum logic {IDLE, RUN} ctrl_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned PRESCALE_DEF        = 8;

endpackage

// File: rtl/btn_conditioner.sv
// One push-button path: 2-flop synchronizer, debounce counter, rising-edge press pulse.
module btn_conditioner
    import count_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync    <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], btn_raw};
            level_q <= level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Driven only by flops; the top registers it again before any output.
    assign press = level & ~level_q;

endmodule

// File: rtl/count_cmd_ctrl.sv
// Command stage for the up/down swap counter: conditions run/step/swap buttons
// and issues registered enable/swap strobes plus prescaled ticks in RUN.
module count_cmd_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned PRESCALE        = PRESCALE_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_run,
    input  logic btn_step,
    input  logic btn_swap,
    output logic enable,
    output logic swap,
    output logic running
);

    localparam int unsigned PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic run_press;
    logic step_press;
    logic swap_press;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
        .clock(clock), .reset_n(reset_n), .btn_raw(btn_run), .press(run_press)
    );
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clock(clock), .reset_n(reset_n), .btn_raw(btn_step), .press(step_press)
    );
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_swap (
        .clock(clock), .reset_n(reset_n), .btn_raw(btn_swap), .press(swap_press)
    );

    ctrl_state_t     state;
    ctrl_state_t     state_nxt;
    logic [PS_W-1:0] presc;
    logic [PS_W-1:0] presc_nxt;
    logic            enable_nxt;
    logic            swap_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            presc   <= '0;
            enable  <= 1'b0;
            swap    <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            enable  <= enable_nxt;
            swap    <= swap_nxt;
            running <= (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt  = state;
        presc_nxt  = '0;
        enable_nxt = 1'b0;
        swap_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (run_press) begin
                    state_nxt = RUN;
                end else if (swap_press) begin
                    enable_nxt = 1'b1;
                    swap_nxt   = 1'b1;
                end else if (step_press) begin
                    enable_nxt = 1'b1;
                end
            end
            RUN: begin
                if (run_press) begin
                    state_nxt = IDLE;
                end else begin
                    presc_nxt = (presc == PS_LAST) ? '0 : presc + PS_W'(1);
                    // A swap press absorbs a coincident tick into one strobe.
                    if (swap_press) begin
                        enable_nxt = 1'b1;
                        swap_nxt   = 1'b1;
                    end else if (presc == PS_LAST) begin
                        enable_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_count_cmd_ctrl.sv
// Directed bench for count_cmd_ctrl with default parameters (debounce 4, prescale 8).
module tb_count_cmd_ctrl;

    logic clock;
    logic reset_n;
    logic btn_run;
    logic btn_step;
    logic btn_swap;
    logic enable;
    logic swap;
    logic running;

    int tests;
    int fails;
    int illegal;

    count_cmd_ctrl #(.DEBOUNCE_CYCLES(4), .PRESCALE(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .btn_run(btn_run), .btn_step(btn_step), .btn_swap(btn_swap),
        .enable(enable), .swap(swap), .running(running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string name;
        logic  run;
        logic  swp;
        logic  stp;
        int    exp_count;
        int    exp_first;
        logic  exp_swap;
        logic  exp_running;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge and watch for swap-without-enable.
    task automatic tick();
        @(posedge clock);
        #1;
        if (swap && !enable) illegal++;
    endtask

    task automatic do_reset();
        btn_run  = 1'b0;
        btn_step = 1'b0;
        btn_swap = 1'b0;
        reset_n  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    int n;
    int first;
    logic fsw;
    int got_e[$];
    logic got_s[$];
    int exp_e[8];
    logic exp_s[8];

    initial begin
        tests = 0; fails = 0; illegal = 0;
        reset_n = 1'b1;
        btn_run = 1'b0; btn_step = 1'b0; btn_swap = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_enable", int'(enable), 0);
        check("reset_swap", int'(swap), 0);
        check("reset_running", int'(running), 0);

        vecs[0] = '{"step",           1'b0, 1'b0, 1'b1, 1,  7, 1'b0, 1'b0};
        vecs[1] = '{"swap",           1'b0, 1'b1, 1'b0, 1,  7, 1'b1, 1'b0};
        vecs[2] = '{"swap_step",      1'b0, 1'b1, 1'b1, 1,  7, 1'b1, 1'b0};
        vecs[3] = '{"run",            1'b1, 1'b0, 1'b0, 0, -1, 1'b0, 1'b1};
        vecs[4] = '{"run_swap",       1'b1, 1'b1, 1'b0, 0, -1, 1'b0, 1'b1};
        vecs[5] = '{"run_swap_step",  1'b1, 1'b1, 1'b1, 0, -1, 1'b0, 1'b1};
        vecs[6] = '{"none",           1'b0, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0};

        // Buttons driven just after edge 0, held through edge 14.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            tick();
            btn_run  = vecs[v].run;
            btn_swap = vecs[v].swp;
            btn_step = vecs[v].stp;
            n = 0; first = -1; fsw = 1'b0;
            for (int e = 1; e <= 14; e++) begin
                tick();
                if (enable) begin
                    n++;
                    if (first < 0) begin
                        first = e;
                        fsw = swap;
                    end
                end
            end
            check({vecs[v].name, "_count"}, n, vecs[v].exp_count);
            check({vecs[v].name, "_first_edge"}, first, vecs[v].exp_first);
            if (vecs[v].exp_count > 0)
                check({vecs[v].name, "_swap"}, int'(fsw), int'(vecs[v].exp_swap));
            check({vecs[v].name, "_running"}, int'(running), int'(vecs[v].exp_running));
        end

        // Bounce rejection: 3-cycle highs never reach the 4-sample threshold.
        do_reset();
        tick();
        n = 0;
        for (int r = 0; r < 5; r++) begin
            btn_swap = 1'b1;
            for (int k = 0; k < 3; k++) begin tick(); if (enable) n++; end
            btn_swap = 1'b0;
            for (int k = 0; k < 3; k++) begin tick(); if (enable) n++; end
        end
        check("bounce_no_enable", n, 0);
        btn_swap = 1'b1;
        n = 0; fsw = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (enable) begin n++; fsw = swap; end
        end
        check("bounce_hold_count", n, 1);
        check("bounce_hold_swap", int'(fsw), 1);

        // RUN: entry at edge 7, ticks every 8; swap aligned to edge 47 tick;
        // run released after 57, pressed again after 66 -> leave RUN at edge 73.
        exp_e = '{15, 23, 31, 39, 47, 55, 63, 71};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        tick();
        btn_run = 1'b1;
        got_e.delete();
        got_s.delete();
        for (int e = 1; e <= 100; e++) begin
            tick();
            if (enable) begin
                got_e.push_back(e);
                got_s.push_back(swap);
            end
            if (e == 6)  check("run_not_yet", int'(running), 0);
            if (e == 7)  check("run_entered", int'(running), 1);
            if (e == 72) check("run_still", int'(running), 1);
            if (e == 73) check("run_left", int'(running), 0);
            if (e == 40) btn_swap = 1'b1;
            if (e == 57) btn_run = 1'b0;
            if (e == 66) btn_run = 1'b1;
        end
        check("run_strobe_count", got_e.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_e.size()) begin
                check($sformatf("run_strobe%0d_edge", i), got_e[i], exp_e[i]);
                check($sformatf("run_strobe%0d_swap", i), int'(got_s[i]), int'(exp_s[i]));
            end
        end

        // Async reset while a tick strobe is high; step held through release.
        do_reset();
        tick();
        btn_run = 1'b1;
        for (int e = 1; e <= 23; e++) tick();
        check("pre_reset_tick", int'(enable), 1);
        check("pre_reset_running", int'(running), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_enable", int'(enable), 0);
        check("async_swap", int'(swap), 0);
        check("async_running", int'(running), 0);
        btn_run  = 1'b0;
        btn_step = 1'b1;
        tick();
        reset_n = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin tick(); if (enable) n++; end
        check("post_reset_held_step", n, 1);
        check("post_reset_idle", int'(running), 0);

        check("swap_only_with_enable", illegal, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
